// File: rtl/code_sender.sv
// Presents a latched 16-bit code to a downstream checker one nibble at a time,
// each nibble qualified by a one-hot enable strobe, then waits for admittance.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_DRIVE | digit shown, enable strobe high
// S_GAP   | enable low, digit held
// S_WAIT  | all digits sent, waiting for admitted or timeout
// S_DONE  | one-cycle done pulse
module code_sender #(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] code,
  input  logic        admitted,
  output logic [3:0]  digit,
  output logic [3:0]  enable,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [15:0] shadow_q;
  logic [3:0]  digit_q;
  logic [3:0]  enable_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        fail_q;

  logic [1:0]  idx_nxt;
  logic [3:0]  nib_nxt;

  assign idx_nxt = idx_q + 2'd1;
  assign nib_nxt = shadow_q[{idx_nxt, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      digit_q  <= '0;
      enable_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q <= code;
            idx_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            digit_q  <= code[3:0];
            enable_q <= 4'b0001;
            busy_q   <= 1'b1;
            state_q  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            enable_q <= '0;
            busy_q   <= 1'b0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_q    <= '0;
            enable_q <= '0;
            state_q  <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (abort) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            enable_q <= '0;
            busy_q   <= 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (idx_q == 2'd3) begin
              digit_q <= '0;
              state_q <= S_WAIT;
            end else begin
              idx_q    <= idx_nxt;
              digit_q  <= nib_nxt;
              enable_q <= 4'b0001 << idx_nxt;
              state_q  <= S_DRIVE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT: begin
          // abort beats admitted, admitted beats the timeout
          if (abort) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            enable_q <= '0;
            busy_q   <= 1'b0;
          end else if (admitted) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (cnt_q == TMO_LAST) begin
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          idx_q    <= '0;
          cnt_q    <= '0;
          digit_q  <= '0;
          enable_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign digit  = digit_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;
  assign fail   = fail_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: a per-cycle expectation queue built from
// the code being sent, compared against the DUT outputs every cycle.
module tb_code_sender;

  localparam int H = 2;
  localparam int G = 1;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, admitted;
  logic [15:0] code;
  logic [3:0]  digit, enable;
  logic        busy, done, pass, fail;

  logic        start1, abort1, admitted1;
  logic [15:0] code1;
  logic [3:0]  digit1, enable1;
  logic        busy1, done1, pass1, fail1;

  int checks = 0;
  int errors = 0;

  logic [11:0] o0, o1;
  assign o0 = {busy, done, pass, fail, enable, digit};
  assign o1 = {busy1, done1, pass1, fail1, enable1, digit1};

  always #5 clk = ~clk;

  code_sender #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .code(code),
    .admitted(admitted), .digit(digit), .enable(enable), .busy(busy),
    .done(done), .pass(pass), .fail(fail)
  );

  code_sender #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .code(code1),
    .admitted(admitted1), .digit(digit1), .enable(enable1), .busy(busy1),
    .done(done1), .pass(pass1), .fail(fail1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // admit_at: WAIT cycle (1-based) on which admitted pulses, 0 = never.
  // abort_at / rst_at: cycle index after start at which to abort / reset, -1 = never.
  task automatic send(input logic [15:0] c, input int admit_at, input int abort_at,
                      input int rst_at, input bit retrig);
    logic [11:0] q[$];
    logic [11:0] e;
    logic [3:0]  nib;
    int n = 0, busy_n = 0, done_n = 0, w;
    bit pass_e;
    for (int i = 0; i < 4; i++) begin
      nib = c[4*i +: 4];
      repeat (H) q.push_back({4'b1000, 4'(1 << i), nib});
      repeat (G) q.push_back({4'b1000, 4'b0000, nib});
    end
    w = (admit_at > 0) ? admit_at : T;
    repeat (w) q.push_back({4'b1000, 8'h00});
    pass_e = (admit_at > 0);
    q.push_back({1'b1, 1'b1, pass_e, !pass_e, 8'h00});
    q.push_back({1'b0, 1'b0, pass_e, !pass_e, 8'h00});
    if (abort_at >= 0) begin
      while (q.size() > abort_at + 1) void'(q.pop_back());
      q.push_back(12'h000);
    end
    if (rst_at >= 0)
      while (q.size() > rst_at + 1) void'(q.pop_back());

    code  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("cycle%0d", n), o0, e);
      if (busy) busy_n++;
      if (done) done_n++;
      admitted = (admit_at > 0 && n == 4*(H+G) + admit_at - 1) || (retrig && n == 2);
      abort    = (n == abort_at);
      if (retrig && n == 1) begin
        start = 1'b1;
        code  = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      if (n == rst_at) begin
        #1 rst = 1'b1;
        #1 chk("async_rst", o0, 0);
      end
      n++;
      @(negedge clk);
    end
    admitted = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    if (rst_at >= 0) begin
      chk("rst_held", o0, 0);
      rst = 1'b0;
      @(negedge clk);
    end
    chk("done_pulses", done_n, (abort_at < 0 && rst_at < 0) ? 1 : 0);
    if (abort_at < 0 && rst_at < 0)
      chk("busy_len", busy_n, 4*(H+G) + w + 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; admitted = 1'b0; code = 16'h0000;
    start1 = 1'b0; abort1 = 1'b0; admitted1 = 1'b0; code1 = 16'h0000;
    #3;
    chk("reset_u0", o0, 0);
    chk("reset_u1", o1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(16'h2171, 2, -1, -1, 1'b0);  // nominal
    send(16'h2171, 0, -1, -1, 1'b0);  // timeout
    send(16'h2171, 0,  6, -1, 1'b0);  // abort while enable=0100
    send(16'h2171, 2, -1, -1, 1'b1);  // re-trigger, code change, stray admitted
    send(16'h2171, 0, -1,  9, 1'b0);  // async reset while enable=1000
    send(16'h2171, 1, -1, -1, 1'b0);  // fresh send after reset
    send(16'h0AF0, 3, -1, -1, 1'b0);  // zero and non-BCD nibbles
    send(16'h2171, T, -1, -1, 1'b0);  // admitted in final timeout cycle

    for (int v = 0; v < 2; v++) begin
      code1  = 16'h4321;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int n = 0; n < 8; n++) begin
        chk($sformatf("edge%0d_c%0d", v, n), o1,
            (n % 2 == 0) ? {4'b1000, 4'(1 << (n/2)), code1[4*(n/2) +: 4]}
                         : {4'b1000, 4'b0000, code1[4*(n/2) +: 4]});
        @(negedge clk);
      end
      chk($sformatf("edge%0d_wait", v), o1, 12'h800);
      admitted1 = 1'b1;
      abort1    = (v == 0);
      @(negedge clk);
      admitted1 = 1'b0;
      abort1    = 1'b0;
      chk($sformatf("edge%0d_end", v), o1, (v == 0) ? 12'h000 : 12'hE00);
      @(negedge clk);
      chk($sformatf("edge%0d_idle", v), o1, (v == 0) ? 12'h000 : 12'h200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
